// File: rtl/date_ctrl.sv
// Calendar controller: day/month state, leap-year month limits,
// year counter carry generation and the user set-mode sequencer.
module date_ctrl #(
    parameter int RST_MONTH = 1,
    parameter int RST_DAY   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [3:0] year_dig1,
    input  logic [3:0] year_dig0,
    output logic       year_cin,
    output logic [3:0] day_dig1,
    output logic [3:0] day_dig0,
    output logic [3:0] mon_dig1,
    output logic [3:0] mon_dig0,
    output logic [1:0] mode,
    output logic       leap
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_YEAR  = 2'd1,
        SET_MONTH = 2'd2,
        SET_DAY   = 2'd3
    } mode_t;

    mode_t      state, state_n;
    logic [4:0] day, day_n;
    logic [3:0] month, month_n;
    logic       cin_n;
    logic [4:0] lim;

    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        if (v >= 5'd30) return {4'd3, 4'(v - 5'd30)};
        if (v >= 5'd20) return {4'd2, 4'(v - 5'd20)};
        if (v >= 5'd10) return {4'd1, 4'(v - 5'd10)};
        return {4'd0, v[3:0]};
    endfunction

    // 00 counts as leap (2000)
    assign leap = (((7'(year_dig1) * 7'd10) + 7'(year_dig0)) % 7'd4) == 7'd0;

    always_comb begin
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: lim = 5'd30;
            4'd2:                    lim = leap ? 5'd29 : 5'd28;
            default:                 lim = 5'd31;
        endcase
    end

    always_comb begin
        state_n = state;
        day_n   = day;
        month_n = month;
        cin_n   = 1'b0;
        if (mode_btn) begin
            state_n = mode_t'(state + 2'd1);
            // clamp on entering and on leaving SET_DAY
            if (state == SET_MONTH || state == SET_DAY)
                day_n = (day > lim) ? lim : day;
        end else begin
            case (state)
                RUN: begin
                    if (tick) begin
                        if (day < lim) begin
                            day_n = day + 5'd1;
                        end else if (month < 4'd12) begin
                            day_n   = 5'd1;
                            month_n = month + 4'd1;
                        end else begin
                            day_n   = 5'd1;
                            month_n = 4'd1;
                            cin_n   = 1'b1;
                        end
                    end
                end
                SET_YEAR: begin
                    if (inc_btn) cin_n = 1'b1;
                end
                SET_MONTH: begin
                    if (inc_btn)
                        month_n = (month >= 4'd12) ? 4'd1 : month + 4'd1;
                end
                SET_DAY: begin
                    if (inc_btn)
                        day_n = (day >= lim) ? 5'd1 : day + 5'd1;
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            day      <= 5'(RST_DAY);
            month    <= 4'(RST_MONTH);
            year_cin <= 1'b0;
        end else begin
            state    <= state_n;
            day      <= day_n;
            month    <= month_n;
            year_cin <= cin_n;
        end
    end

    assign mode                 = state;
    assign {day_dig1, day_dig0} = to_bcd(day);
    assign {mon_dig1, mon_dig0} = to_bcd({1'b0, month});

endmodule

// File: tb/tb_date_ctrl.sv
// Scoreboard bench for date_ctrl with a behavioural year counter
// and a calendar reference model.
module tb_date_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [3:0] year_dig1, year_dig0;
    logic       year_cin;
    logic [3:0] day_dig1, day_dig0, mon_dig1, mon_dig0;
    logic [1:0] mode;
    logic       leap;

    int   year_reg = 0;
    logic yl = 1'b0;
    int   yv = 0;

    date_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn),
        .inc_btn(inc_btn), .year_dig1(year_dig1), .year_dig0(year_dig0),
        .year_cin(year_cin), .day_dig1(day_dig1), .day_dig0(day_dig0),
        .mon_dig1(mon_dig1), .mon_dig0(mon_dig0), .mode(mode), .leap(leap)
    );

    always #5 clk = ~clk;

    // external two-digit year counter
    always @(posedge clk) begin
        if (yl) year_reg <= yv;
        else if (year_cin) year_reg <= (year_reg + 1) % 100;
    end
    assign year_dig1 = 4'(year_reg / 10);
    assign year_dig0 = 4'(year_reg % 10);

    typedef struct {
        int day; int mon; int mode; int cin; int leap; int year;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad = 0;

    int m_day = 1, m_mon = 1, m_mode = 0, m_cin = 0, m_year = 0;
    int days_in[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

    function automatic int month_len(int mon, int yr);
        if (mon == 2 && yr % 4 == 0) return 29;
        return days_in[mon - 1];
    endfunction

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    function automatic void model_edge(bit tk, bit mb, bit ib, bit ld, int ly);
        int lim, nd, nm, nmode, ncin, ny;
        lim   = month_len(m_mon, m_year);
        nd    = m_day;
        nm    = m_mon;
        nmode = m_mode;
        ncin  = 0;
        ny    = ld ? ly : (m_cin != 0 ? (m_year + 1) % 100 : m_year);
        if (mb) begin
            nmode = (m_mode + 1) % 4;
            if ((m_mode == 2 || m_mode == 3) && m_day > lim) nd = lim;
        end else if (m_mode == 0 && tk) begin
            if (m_day < lim) nd = m_day + 1;
            else begin
                nd = 1;
                if (m_mon < 12) nm = m_mon + 1;
                else begin nm = 1; ncin = 1; end
            end
        end else if (m_mode == 1 && ib) ncin = 1;
        else if (m_mode == 2 && ib) nm = (m_mon % 12) + 1;
        else if (m_mode == 3 && ib) nd = (m_day >= lim) ? 1 : m_day + 1;
        m_day = nd; m_mon = nm; m_mode = nmode; m_cin = ncin; m_year = ny;
    endfunction

    task automatic step(bit tk, bit mb, bit ib, bit ld = 1'b0, int ly = 0);
        exp_t e;
        @(posedge clk);
        #2;
        tick = tk; mode_btn = mb; inc_btn = ib; yl = ld; yv = ly;
        model_edge(tk, mb, ib, ld, ly);
        e.day = m_day; e.mon = m_mon; e.mode = m_mode; e.cin = m_cin;
        e.year = m_year; e.leap = (m_year % 4 == 0) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        tick = 0; mode_btn = 0; inc_btn = 0; yl = 0;
        rst = 1'b1;
        q.delete();
        #1;
        chk("rst_day1", int'(day_dig1), 0);
        chk("rst_day0", int'(day_dig0), 1);
        chk("rst_mon1", int'(mon_dig1), 0);
        chk("rst_mon0", int'(mon_dig0), 1);
        chk("rst_mode", int'(mode), 0);
        chk("rst_cin", int'(year_cin), 0);
        m_day = 1; m_mon = 1; m_mode = 0; m_cin = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic set_date(int m, int d);
        int guard;
        step(0, 1, 0);
        step(0, 1, 0);
        guard = 0;
        while (m_mon != m && guard < 20) begin step(0, 0, 1); guard++; end
        step(0, 1, 0);
        guard = 0;
        while (m_day != d && guard < 40) begin step(0, 0, 1); guard++; end
        step(0, 1, 0);
    endtask

    // monitor: outputs are compared one time unit after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("day_dig1", int'(day_dig1), e.day / 10);
                chk("day_dig0", int'(day_dig0), e.day % 10);
                chk("mon_dig1", int'(mon_dig1), e.mon / 10);
                chk("mon_dig0", int'(mon_dig0), e.mon % 10);
                chk("mode", int'(mode), e.mode);
                chk("year_cin", int'(year_cin), e.cin);
                chk("leap", int'(leap), e.leap);
                chk("year", year_reg, e.year);
            end
        end
    end

    initial begin
        do_reset();
        for (int i = 0; i < 31; i++) step(1, 0, 0);

        step(0, 0, 0, 1'b1, 23);
        set_date(2, 28);
        step(1, 0, 0);
        step(0, 0, 0, 1'b1, 24);
        set_date(2, 28);
        step(1, 0, 0);
        step(1, 0, 0);

        step(0, 0, 0, 1'b1, 99);
        set_date(12, 31);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);

        step(0, 0, 0, 1'b1, 23);
        set_date(1, 31);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 1, 0);

        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);

        step(1, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);

        set_date(12, 31);
        step(1, 0, 0);
        do_reset();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            step($urandom_range(0, 1) == 1,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 59) == 0,
                 int'($urandom_range(0, 99)));
        end
        step(0, 0, 0);
        @(posedge clk);
        #3;
        if (q.size() != 0) chk("queue_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/date_ctrl.md
Name: date_ctrl

Overview:
- Calendar controller that sequences the cascaded date datapath: holds day and month, drives the carry-in of the external two-digit (00-99) year counter, and reads back that counter's BCD digits for leap-year decisions.
- Provides a user set mode (year -> month -> day) driven by debounced one-pulse buttons.
- Sits between the one-pulse button logic / day-tick divider and the year counter plus the seven-segment display mux.

Parameters:
- RST_MONTH, 1, month value loaded on reset (legal range 1-12)
- RST_DAY, 1, day value loaded on reset (legal range 1-28)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- tick  input  1  one-cycle day-advance pulse
- mode_btn  input  1  one-cycle pulse; advances the mode state machine
- inc_btn  input  1  one-cycle pulse; increments the field selected in set mode
- year_dig1  input  4  year tens digit (BCD) from the year counter
- year_dig0  input  4  year units digit (BCD) from the year counter
- year_cin  output  1  registered one-cycle carry into the year counter
- day_dig1  output  4  day tens digit (BCD)
- day_dig0  output  4  day units digit (BCD)
- mon_dig1  output  4  month tens digit (BCD)
- mon_dig0  output  4  month units digit (BCD)
- mode  output  2  0=RUN, 1=SET_YEAR, 2=SET_MONTH, 3=SET_DAY
- leap  output  1  combinational; current year is a leap year

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-high; all state updates on posedge clk.
- Reset values: day=RST_DAY, month=RST_MONTH, mode=RUN, year_cin=0.
- Internal representation: day (5 bit, 1-31) and month (4 bit, 1-12) are held as binary.
  - Digit outputs: value/10 and value%10.
- Leap rule: Y = year_dig1*10 + year_dig0. leap=1 iff Y%4==0, so 00 is a leap year (2000).
- Month length lim:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - Month 2: 29 if leap, else 28.
- FSM: each mode_btn pulse moves RUN->SET_YEAR->SET_MONTH->SET_DAY->RUN.
- Priority: mode_btn has priority over tick and inc_btn in the same cycle; the losing pulse is dropped, not queued.
- RUN state, on tick:
  - If day<lim: day+1.
  - Else if month<12: day=1, month+1.
  - Else (Dec 31): day=1, month=1, year_cin=1 on the following cycle only.
  - inc_btn is ignored in RUN.
- SET states: tick is ignored, so time does not advance while setting.
- SET_YEAR, on inc_btn: year_cin pulses for exactly one cycle. The year counter handles its own 99->00 wrap.
- SET_MONTH, on inc_btn: month+1, wrapping 12->1. Day is not changed.
- SET_DAY, on inc_btn: day+1, wrapping lim->1.
- Clamp: on the edge entering SET_DAY and on the edge SET_DAY->RUN, day is loaded with min(day, lim). lim is computed from the month register and year digits at that edge.
- year_cin timing:
  - Registered: asserted in the cycle after the triggering edge, deasserted the next cycle.
  - The year digits therefore update 2 edges after the triggering pulse.
  - leap may be stale during that window; this is harmless because day=1 or the controller is in SET_YEAR.
- Back-to-back pulses:
  - A tick in the year_cin cycle is processed normally (Jan 1->Jan 2).
  - inc_btn pulses on consecutive cycles in SET_YEAR each produce their own year_cin pulse, so year_cin may stay high for consecutive cycles. Each high cycle is one carry.
- Reset mid-operation: reset takes effect immediately (asynchronous); a pending year_cin is cancelled.

Test Plan:
- Reset, then idle: day=01, month=01, mode=0, year_cin=0; 31 ticks give day=01 month=02.
- Year=23, set Feb 28, tick -> Mar 1, no year_cin. Year=24, Feb 28, tick -> Feb 29; next tick -> Mar 1.
- Dec 31 in RUN with year=99, tick -> day=01 month=01; year_cin high exactly one cycle; year counter reads 00 two edges after the tick.
- Set mode at Jan 31, year=23: mode, mode (SET_MONTH), inc -> month 2, day still 31; mode (SET_DAY) -> day clamped to 28; inc -> day 01; mode -> RUN, mode=0.
- In SET_YEAR, 3 inc pulses on consecutive cycles -> 3 year_cin cycles, year +3. A tick during SET states changes nothing.
- Same-cycle mode_btn+tick in RUN -> mode=1, day unchanged. Assert rst while year_cin is pending -> year_cin=0 immediately and all outputs at reset values.
